isodata_cluster_stats: RTL and testbench
========================================

# isodata_cluster_stats

Downstream stage of `isodata_accelerator`. It consumes a stream of (point, assigned cluster) pairs and accumulates per-cluster point counts and coordinate sums. It then computes each cluster's mean centre in signed Q(DATA_WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS fixed point. It emits one statistics record per cluster, flagging empty and under-populated clusters so the ISODATA split/merge/discard controller can act on them.

## Interface
Parameters:
- `DATA_WIDTH`, 32: coordinate width, signed fixed point.
- `FRACTIONAL_BITS`, 16: fractional bits of coordinates.
- `NUM_POINTS`, 128: maximum points per pass.
- `NUM_CLUSTERS`, 8: number of clusters.
- `MIN_CLUSTER_SIZE`, 2: a cluster with a count below this value is flagged `out_small`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input record valid.
- `in_ready`  out  1  block can accept a record.
- `in_x`, `in_y`  in  DATA_WIDTH  point coordinates, signed.
- `in_cluster`  in  CW=$clog2(NUM_CLUSTERS)  assigned cluster.
- `in_last`  in  1  final point of the pass.
- `out_valid`  out  1  output record valid.
- `out_ready`  in  1  consumer accepts the record.
- `out_cluster`  out  CW  cluster index.
- `out_count`  out  $clog2(NUM_POINTS+1)  points in the cluster.
- `out_center_x`, `out_center_y`  out  DATA_WIDTH  mean coordinates, signed.
- `out_empty`  out  1  count == 0.
- `out_small`  out  1  count < MIN_CLUSTER_SIZE.
- `out_last`  out  1  record for cluster NUM_CLUSTERS-1.
- `busy`  out  1  high in every state except ACCUM.

## Operation
- **States:** ACCUM → DIV_X → DIV_Y → EMIT → (DIV_X of the next cluster, or ACCUM after the last cluster).
- **ACCUM**
  - `in_ready`=1.
  - On each handshake (`in_valid` && `in_ready`): `sum_x[c]` += sign-extended `in_x`, `sum_y[c]` += sign-extended `in_y`, `count[c]`++.
  - Accumulator width SW = DATA_WIDTH + $clog2(NUM_POINTS).
  - A handshake with `in_last`=1 is accumulated, then the state moves to DIV_X with cluster index k=0.
- **Count saturation:** `count` saturates at NUM_POINTS. Once it is saturated, further points for that cluster are accepted but not added.
- **DIV_X / DIV_Y:** restoring divide of |sum| by count, one quotient bit per cycle, SW cycles each.
  - Sign is applied afterwards, so the result truncates toward zero.
  - The quotient is truncated to DATA_WIDTH. No saturation is needed because a mean always lies within the coordinate range.
- **Empty cluster (count==0):** both divides are skipped; the state goes from DIV_X straight to EMIT with centres = 0 and `out_empty`=1.
- **EMIT**
  - Drives `out_valid` with the record for cluster k.
  - All out_* fields are registered and held stable until `out_ready`.
  - On the handshake: if k<NUM_CLUSTERS-1, k++ and go to DIV_X. Otherwise clear all sums and counts and go to ACCUM.
- **Reset (any time, including mid-divide or mid-EMIT):**
  - State → ACCUM; all sums, counts and k = 0.
  - `out_valid`=0, `busy`=0, `in_ready`=0 while `rst` is asserted, then 1.
  - All out_* data fields = 0.

## Timing
- `in_ready` is a registered state decode, not combinationally dependent on `in_valid`.
- Sustained accept rate is 1 record/cycle in ACCUM.
- First `out_valid`:
  - Non-empty cluster 0: 2·SW+1 cycles after the `in_last` handshake edge.
  - Empty cluster 0: 1 cycle after that edge.
- Per-cluster gap after each `out_ready` handshake: 2·SW+1 cycles (non-empty) or 1 cycle (empty).
- `out_valid` never drops without a handshake.
- `in_ready`=0 from the `in_last` handshake until the cycle after the final output handshake.

## Structure
- Package `isodata_pkg` holds:
  - the state enum;
  - a `cluster_stats_t` struct with count, centre_x, centre_y, empty, small;
  - the SW and CW width functions;
  - the shared DATA_WIDTH/FRACTIONAL_BITS defaults.
- Sub-module `isodata_seq_divider`:
  - signed SW-bit dividend, unsigned count divisor;
  - `start`/`done` handshake, SW-cycle latency, truncation toward zero.
  - It is instantiated once and reused for x then y.

## Test plan
- **Basic mean:** cluster 0 gets (1.0,2.0) and (3.0,4.0), with `in_last` on the second → record k=0 has count=2, centre 0x00020000/0x00030000, `out_small`=0; clusters 1–7 have `out_empty`=1, `out_small`=1, centre 0.
- **Sign and truncation:**
  - (−1.5,0) and (0.5,0) in cluster 3 → `out_center_x` = 0xFFFF8000.
  - x = −1 LSB and −2 LSB in cluster 2 → `out_center_x` = 0xFFFFFFFF (−3/2 truncated to −1).
- **Backpressure:** hold `out_ready`=0 for 50 cycles during EMIT → `out_valid` and all fields are stable; exactly NUM_CLUSTERS records are emitted and only the last has `out_last`=1.
- **Full load:** 128 points of 0x7FFF0000 in cluster 7 → count=128 (no wrap), centre 0x7FFF0000; sum width does not overflow.
- **Reset mid-divide:** assert `rst` 10 cycles into DIV_Y → `out_valid`=0 and `busy`=0 immediately; a new pass afterwards yields centres using only post-reset points.
- **Latency check:** measure from the `in_last` handshake to the first `out_valid` = 2·SW+1 = 79 cycles at default parameters.

Source files
------------

// File: rtl/isodata_pkg.sv
// Shared types and width helpers for the ISODATA cluster statistics stage.
package isodata_pkg;
   localparam int DEF_DATA_WIDTH      = 32;
   localparam int DEF_FRACTIONAL_BITS = 16;
   localparam int DEF_NUM_POINTS      = 128;
   localparam int DEF_CNT_W           = $clog2(DEF_NUM_POINTS + 1);

   typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, EMIT} state_t;

   typedef struct packed {
      logic [DEF_CNT_W-1:0]      count;
      logic [DEF_DATA_WIDTH-1:0] centre_x;
      logic [DEF_DATA_WIDTH-1:0] centre_y;
      logic                      is_empty;
      logic                      is_small;
   } cluster_stats_t;

   function automatic int sum_width(int dw, int np);
      return dw + $clog2(np);
   endfunction

   function automatic int clust_width(int nc);
      return (nc > 1) ? $clog2(nc) : 1;
   endfunction
endpackage

// File: rtl/isodata_seq_divider.sv
// Restoring divider: |dividend| / divisor, one quotient bit per cycle, sign applied last.
module isodata_seq_divider #(
   parameter int SW   = 39,
   parameter int DW   = 32,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SW-1:0]   dividend,
   input  logic [CNTW-1:0] divisor,
   output logic            done,
   output logic [DW-1:0]   quotient
);
   localparam int LW = $clog2(SW + 1);

   logic [SW-1:0]   dvd, dvd_src, dvd_nxt;
   logic [CNTW-1:0] rem, rem_src, rem_nxt, dsr, dsr_src;
   logic [CNTW:0]   trial;
   logic [LW-1:0]   left;
   logic            neg;

   // The first quotient bit is produced on the start edge itself.
   always_comb begin
      dvd_src = start ? (dividend[SW-1] ? (~dividend + 1'b1) : dividend) : dvd;
      rem_src = start ? '0 : rem;
      dsr_src = start ? divisor : dsr;
      trial   = {rem_src, dvd_src[SW-1]};
      rem_nxt = trial[CNTW-1:0];
      dvd_nxt = {dvd_src[SW-2:0], 1'b0};
      if (trial >= {1'b0, dsr_src}) begin
         rem_nxt = CNTW'(trial - {1'b0, dsr_src});
         dvd_nxt = {dvd_src[SW-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd  <= '0;
         rem  <= '0;
         dsr  <= '0;
         neg  <= 1'b0;
         left <= '0;
         done <= 1'b0;
      end else if (start) begin
         dvd  <= dvd_nxt;
         rem  <= rem_nxt;
         dsr  <= divisor;
         neg  <= dividend[SW-1];
         left <= LW'(SW - 1);
         done <= (SW == 1);
      end else if (left != '0) begin
         dvd  <= dvd_nxt;
         rem  <= rem_nxt;
         left <= left - 1'b1;
         done <= (left == LW'(1));
      end
   end

   assign quotient = DW'(neg ? (~dvd + 1'b1) : dvd);
endmodule

// File: rtl/isodata_cluster_stats.sv
// Accumulates per-cluster counts/sums, then emits one mean-centre record per cluster.
module isodata_cluster_stats
   import isodata_pkg::*;
#(
   parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int FRACTIONAL_BITS  = DEF_FRACTIONAL_BITS,
   parameter int NUM_POINTS       = DEF_NUM_POINTS,
   parameter int NUM_CLUSTERS     = 8,
   parameter int MIN_CLUSTER_SIZE = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [DATA_WIDTH-1:0]                 in_x,
   input  logic [DATA_WIDTH-1:0]                 in_y,
   input  logic [clust_width(NUM_CLUSTERS)-1:0]  in_cluster,
   input  logic                                  in_last,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [clust_width(NUM_CLUSTERS)-1:0]  out_cluster,
   output logic [$clog2(NUM_POINTS+1)-1:0]       out_count,
   output logic [DATA_WIDTH-1:0]                 out_center_x,
   output logic [DATA_WIDTH-1:0]                 out_center_y,
   output logic                                  out_empty,
   output logic                                  out_small,
   output logic                                  out_last,
   output logic                                  busy
);
   localparam int SW   = sum_width(DATA_WIDTH, NUM_POINTS);
   localparam int CW   = clust_width(NUM_CLUSTERS);
   localparam int CNTW = $clog2(NUM_POINTS + 1);

   if (FRACTIONAL_BITS >= DATA_WIDTH) begin : g_bad_frac
      $error("FRACTIONAL_BITS must be smaller than DATA_WIDTH");
   end

   state_t                state;
   logic [SW-1:0]         sum_x [NUM_CLUSTERS];
   logic [SW-1:0]         sum_y [NUM_CLUSTERS];
   logic [CNTW-1:0]       cnt   [NUM_CLUSTERS];
   logic [CW-1:0]         k;
   logic                  div_pend, div_start, div_done;
   logic [SW-1:0]         div_dvd;
   logic [DATA_WIDTH-1:0] div_q, cx;
   logic [CNTW-1:0]       cnt_k;
   logic                  cnt_small, accept, k_last;

   assign cnt_k     = cnt[k];
   assign cnt_small = int'(cnt_k) < MIN_CLUSTER_SIZE;
   assign k_last    = (k == CW'(NUM_CLUSTERS - 1));
   assign accept    = in_valid && in_ready;
   assign busy      = (state != ACCUM);

   // div_pend marks a fresh cluster: start on x; otherwise a finished x chains into y.
   assign div_start = (state == DIV_X) && (cnt_k != '0) && (div_pend || div_done);
   assign div_dvd   = div_pend ? sum_x[k] : sum_y[k];

   isodata_seq_divider #(.SW(SW), .DW(DATA_WIDTH), .CNTW(CNTW)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (div_dvd),
      .divisor  (cnt_k),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ACCUM;
         k            <= '0;
         div_pend     <= 1'b0;
         cx           <= '0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_cluster  <= '0;
         out_count    <= '0;
         out_center_x <= '0;
         out_center_y <= '0;
         out_empty    <= 1'b0;
         out_small    <= 1'b0;
         out_last     <= 1'b0;
         for (int i = 0; i < NUM_CLUSTERS; i++) begin
            sum_x[i] <= '0;
            sum_y[i] <= '0;
            cnt[i]   <= '0;
         end
      end else begin
         case (state)
            ACCUM: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (cnt[in_cluster] != CNTW'(NUM_POINTS)) begin
                     sum_x[in_cluster] <= sum_x[in_cluster] + {{(SW-DATA_WIDTH){in_x[DATA_WIDTH-1]}}, in_x};
                     sum_y[in_cluster] <= sum_y[in_cluster] + {{(SW-DATA_WIDTH){in_y[DATA_WIDTH-1]}}, in_y};
                     cnt[in_cluster]   <= cnt[in_cluster] + 1'b1;
                  end
                  if (in_last) begin
                     state    <= DIV_X;
                     k        <= '0;
                     div_pend <= 1'b1;
                     in_ready <= 1'b0;
                  end
               end
            end
            DIV_X: begin
               if (cnt_k == '0) begin
                  state        <= EMIT;
                  div_pend     <= 1'b0;
                  out_valid    <= 1'b1;
                  out_cluster  <= k;
                  out_count    <= cnt_k;
                  out_center_x <= '0;
                  out_center_y <= '0;
                  out_empty    <= 1'b1;
                  out_small    <= cnt_small;
                  out_last     <= k_last;
               end else if (div_pend) begin
                  div_pend <= 1'b0;
               end else if (div_done) begin
                  cx    <= div_q;
                  state <= DIV_Y;
               end
            end
            DIV_Y: begin
               if (div_done) begin
                  state        <= EMIT;
                  out_valid    <= 1'b1;
                  out_cluster  <= k;
                  out_count    <= cnt_k;
                  out_center_x <= cx;
                  out_center_y <= div_q;
                  out_empty    <= 1'b0;
                  out_small    <= cnt_small;
                  out_last     <= k_last;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (k_last) begin
                     state    <= ACCUM;
                     in_ready <= 1'b1;
                     for (int i = 0; i < NUM_CLUSTERS; i++) begin
                        sum_x[i] <= '0;
                        sum_y[i] <= '0;
                        cnt[i]   <= '0;
                     end
                  end else begin
                     k        <= k + 1'b1;
                     div_pend <= 1'b1;
                     state    <= DIV_X;
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_isodata_cluster_stats.sv
// Self-checking bench: table-driven passes plus latency, backpressure, saturation and reset sequences.
module tb_isodata_cluster_stats;
   import isodata_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
   logic [31:0] in_x = '0, in_y = '0;
   logic [2:0]  in_cluster = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [2:0]  out_cluster;
   logic [7:0]  out_count;
   logic [31:0] out_center_x, out_center_y;
   logic        out_empty, out_small, out_last, busy;

   always #5 clk = ~clk;

   isodata_cluster_stats dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_cluster(in_cluster), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_cluster(out_cluster),
      .out_count(out_count), .out_center_x(out_center_x), .out_center_y(out_center_y),
      .out_empty(out_empty), .out_small(out_small), .out_last(out_last), .busy(busy)
   );

   typedef struct {
      int             cl;
      cluster_stats_t st;
      logic           last;
   } exp_t;

   typedef struct {
      int          cl;
      int          n;
      logic [31:0] x0, y0, x1, y1;
      int          ecnt;
      logic [31:0] ecx, ecy;
   } tv_t;

   exp_t exp_q[$];
   exp_t mon_e;
   tv_t  tv[6];
   int   checks = 0, errors = 0, records = 0, rec_base = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Scoreboard: the pass's target cluster gets the given stats, all others are empty.
   task automatic push_pass(input int cl, input int cnt, input logic [31:0] cx, input logic [31:0] cy);
      exp_t e;
      rec_base = records;
      for (int c = 0; c < 8; c++) begin
         e.cl   = c;
         e.last = (c == 7);
         if (c == cl) e.st = '{count: 8'(cnt), centre_x: cx, centre_y: cy, is_empty: 1'b0, is_small: (cnt < 2)};
         else         e.st = '{count: 8'd0, centre_x: 32'd0, centre_y: 32'd0, is_empty: 1'b1, is_small: 1'b1};
         exp_q.push_back(e);
      end
   endtask

   task automatic send(input int c, input logic [31:0] x, input logic [31:0] y, input logic last);
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b1; in_cluster = 3'(c); in_x = x; in_y = y; in_last = last;
      while (!in_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_pass();
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      chk("pass_done", {63'd0, in_ready}, 64'd1);
      chk("pass_records", 64'(records - rec_base), 64'd8);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic measure_latency(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (!out_valid && n < 300);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_record: cluster %0d with no expectation", out_cluster);
         end else begin
            mon_e = exp_q.pop_front();
            records++;
            chk("rec_cluster", 64'(out_cluster), 64'(mon_e.cl));
            chk("rec_count", 64'(out_count), 64'(mon_e.st.count));
            chk("rec_cx", 64'(out_center_x), 64'(mon_e.st.centre_x));
            chk("rec_cy", 64'(out_center_y), 64'(mon_e.st.centre_y));
            chk("rec_empty", 64'(out_empty), 64'(mon_e.st.is_empty));
            chk("rec_small", 64'(out_small), 64'(mon_e.st.is_small));
            chk("rec_last", 64'(out_last), 64'(mon_e.last));
         end
      end
   end

   initial begin
      int n;
      logic [87:0] snap;
      logic stable;

      tv[0] = '{0, 2, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 2, 32'h0002_0000, 32'h0003_0000};
      tv[1] = '{3, 2, 32'hFFFE_8000, 32'h0, 32'h0000_8000, 32'h0, 2, 32'hFFFF_8000, 32'h0};
      tv[2] = '{2, 2, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 32'h5, 2, 32'hFFFF_FFFF, 32'h2};
      tv[3] = '{5, 2, 32'h7, 32'hFFFF_FFF9, 32'h0, 32'h0, 2, 32'h3, 32'hFFFF_FFFD};
      tv[4] = '{7, 2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 2, 32'h8000_0000, 32'h7FFF_FFFF};
      tv[5] = '{1, 1, 32'h0001_2345, 32'hFFFF_FF00, 32'h0, 32'h0, 1, 32'h0001_2345, 32'hFFFF_FF00};

      rst = 1'b1;
      #12;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_count", 64'(out_count), 64'd0);
      chk("rst_cx", 64'(out_center_x), 64'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      for (int i = 0; i < 6; i++) begin
         push_pass(tv[i].cl, tv[i].ecnt, tv[i].ecx, tv[i].ecy);
         send(tv[i].cl, tv[i].x0, tv[i].y0, tv[i].n == 1);
         if (tv[i].n == 2) send(tv[i].cl, tv[i].x1, tv[i].y1, 1'b1);
         wait_pass();
      end

      // First-record latency, non-empty then empty cluster 0
      push_pass(0, 2, 32'h0002_0000, 32'h0003_0000);
      send(0, 32'h0001_0000, 32'h0002_0000, 1'b0);
      send(0, 32'h0003_0000, 32'h0004_0000, 1'b1);
      measure_latency(n);
      chk("lat_nonempty", 64'(n), 64'd79);
      wait_pass();
      push_pass(5, 1, 32'h100, 32'h200);
      send(5, 32'h100, 32'h200, 1'b1);
      measure_latency(n);
      chk("lat_empty", 64'(n), 64'd1);
      wait_pass();

      // Backpressure: record must hold for 50 cycles
      out_ready = 1'b0;
      push_pass(6, 2, 32'h0002_0000, 32'h0001_0000);
      send(6, 32'h0003_0000, 32'hFFFF_0000, 1'b0);
      send(6, 32'h0001_0000, 32'h0003_0000, 1'b1);
      measure_latency(n);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      snap = {out_cluster, out_count, out_center_x, out_center_y, out_empty, out_small, out_last, 13'd0};
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (!out_valid || snap != {out_cluster, out_count, out_center_x, out_center_y, out_empty, out_small, out_last, 13'd0})
            stable = 1'b0;
      end
      chk("bp_stable", {63'd0, stable}, 64'd1);
      out_ready = 1'b1;
      wait_pass();

      // Full load plus two extra points that must be ignored after saturation
      push_pass(7, 128, 32'h7FFF_0000, 32'h7FFF_0000);
      for (int i = 0; i < 130; i++) begin
         if (i < 128) send(7, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0);
         else         send(7, 32'h8000_0000, 32'h8000_0000, i == 129);
      end
      wait_pass();

      // Reset 10 cycles into DIV_Y of cluster 0
      push_pass(0, 1, 32'h0001_0000, 32'h0002_0000);
      send(0, 32'h0001_0000, 32'h0002_0000, 1'b0);
      send(4, 32'h0004_0000, 32'h0004_0000, 1'b1);
      repeat (50) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("mid_rst_cx", 64'(out_center_x), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_pass(0, 1, 32'h0005_0000, 32'h0006_0000);
      send(0, 32'h0005_0000, 32'h0006_0000, 1'b1);
      wait_pass();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
